// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the riscv_mem_loader byte-stream loader.
// Optional checksum trailer is enabled with the RISCV_LOADER_CSUM_EN macro.
package riscv_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CNT0 = 4'd1,
        S_CNT1 = 4'd2,
        S_TGT  = 4'd3,
        S_ADR0 = 4'd4,
        S_ADR1 = 4'd5,
        S_DATA = 4'd6,
        S_WR   = 4'd7,
        S_CSUM = 4'd8,
        S_ERR  = 4'd9
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TGT_IMEM  = 8'h00;
    localparam logic [7:0] TGT_DMEM  = 8'h01;

    function automatic logic is_target(input logic [7:0] b);
        return (b == TGT_IMEM) || (b == TGT_DMEM);
    endfunction

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/riscv_mem_loader_word_asm.sv
// Little-endian word assembler: first byte lands in bits [7:0], word_valid
// fires combinationally alongside the 4th byte so the caller can capture it.
module loader_word_asm
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q,   idx_d;

    // next-state for shift register and byte index
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr) begin
            shift_d = 32'h0000_0000;
            idx_d   = 2'd0;
        end else if (shift) begin
            shift_d = {byte_in, shift_q[31:8]};
            idx_d   = idx_q + 2'd1;
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // word view including the byte being accepted this cycle
    always_comb begin
        word       = {byte_in, shift_q[31:8]};
        word_valid = shift && !clr && (idx_q == 2'd3);
    end

    // assembler state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= 32'h0000_0000;
            idx_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/riscv_mem_loader.sv
// Framed byte-stream loader writing imem/dmem and holding the core in reset
// while loading. Define RISCV_LOADER_CSUM_EN to require a trailing XOR checksum.
module riscv_mem_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    loader_state_e      state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         adr_lo_q, adr_lo_d;
    logic [7:0]         csum_q, csum_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               core_hold_q, core_hold_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;

    logic               accept_s;
    logic               sync_start_s;
    logic               asm_shift_s;
    logic               asm_valid_s;
    logic [31:0]        asm_word_s;
    logic [15:0]        adr_full_s;
    logic [17:0]        end_s;
    logic [17:0]        limit_s;
    logic               hi_bits_s;
    logic               finish_s;

    // transfer qualification and address range checks
    always_comb begin
        accept_s     = in_valid && in_ready_q;
        sync_start_s = accept_s && (in_data == SYNC_BYTE)
                       && ((state_q == S_IDLE) || (state_q == S_ERR));
        asm_shift_s  = accept_s && (state_q == S_DATA);
        adr_full_s   = {in_data, adr_lo_q};
        end_s        = {2'b00, adr_full_s} + {2'b00, cnt_q};
        limit_s      = 18'd1 << ADDR_W;
        hi_bits_s    = (adr_full_s >> ADDR_W) != 16'h0000;
    end

    loader_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (sync_start_s),
        .shift      (asm_shift_s),
        .byte_in    (in_data),
        .word_valid (asm_valid_s),
        .word       (asm_word_s)
    );

    // frame FSM next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_lo_d    = adr_lo_q;
        csum_d      = csum_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        finish_s    = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (sync_start_s) begin
                    state_d     = S_CNT0;
                    csum_d      = 8'h00;
                    core_hold_d = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_CNT0: begin
                if (accept_s) begin
                    cnt_d[7:0] = in_data;
                    csum_d     = csum_step(csum_q, in_data);
                    state_d    = S_CNT1;
                end else begin
                    state_d = state_q;
                end
            end
            S_CNT1: begin
                if (accept_s) begin
                    cnt_d[15:8] = in_data;
                    csum_d      = csum_step(csum_q, in_data);
                    state_d     = S_TGT;
                end else begin
                    state_d = state_q;
                end
            end
            S_TGT: begin
                if (accept_s && is_target(in_data)) begin
                    mem_sel_d = in_data[0];
                    csum_d    = csum_step(csum_q, in_data);
                    state_d   = S_ADR0;
                end else if (accept_s) begin
                    load_err_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    state_d = state_q;
                end
            end
            S_ADR0: begin
                if (accept_s) begin
                    adr_lo_d = in_data;
                    csum_d   = csum_step(csum_q, in_data);
                    state_d  = S_ADR1;
                end else begin
                    state_d = state_q;
                end
            end
            S_ADR1: begin
                if (accept_s && (hi_bits_s || (end_s > limit_s))) begin
                    load_err_d = 1'b1;
                    state_d    = S_ERR;
                end else if (accept_s) begin
                    ptr_d   = adr_full_s[ADDR_W-1:0];
                    csum_d  = csum_step(csum_q, in_data);
                    state_d = S_DATA;
                    if (cnt_q == 16'd0) begin
                        finish_s = 1'b1;
                    end else begin
                        finish_s = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    csum_d = csum_step(csum_q, in_data);
                end else begin
                    csum_d = csum_q;
                end
                // the 4th byte is captured straight from the assembler input
                if (asm_valid_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = asm_word_s;
                    state_d     = S_WR;
                end else begin
                    state_d = state_q;
                end
            end
            S_WR: begin
                ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    finish_s = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef RISCV_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept_s && (in_data == csum_q)) begin
                    core_hold_d = 1'b0;
                    load_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (accept_s) begin
                    load_err_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish_s) begin
`ifdef RISCV_LOADER_CSUM_EN
            state_d     = S_CSUM;
`else
            state_d     = S_IDLE;
            core_hold_d = 1'b0;
            load_done_d = 1'b1;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // ready is registered from the upcoming state, low only while writing
    always_comb begin
        in_ready_d = (state_d != S_WR);
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'h0000;
            adr_lo_q    <= 8'h00;
            csum_q      <= 8'h00;
            ptr_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_lo_q    <= adr_lo_d;
            csum_q      <= csum_d;
            ptr_q       <= ptr_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Directed testbench for riscv_mem_loader (ADDR_W=8), covering both builds of
// the RISCV_LOADER_CSUM_EN checksum option.
module tb_riscv_mem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int data_end_cyc = 0;
    int rdy_low = 0;
    int base;
    int rl_base;

    logic [7:0]  frame_q[$];
    logic [7:0]  we_addr[$];
    logic [31:0] we_data[$];
    logic        we_sel[$];
    int          we_cyc[$];

    riscv_mem_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // log every write strobe and every not-ready cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
            we_sel.push_back(mem_sel);
            we_cyc.push_back(cyc);
        end
        if (in_ready === 1'b0) rdy_low <= rdy_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            acc_cyc = cyc;
        end
    endtask

    task automatic send_frame(input bit with_csum, input logic [7:0] cs_flip);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0) cs = cs ^ frame_q[i];
            send_byte(frame_q[i]);
        end
        data_end_cyc = acc_cyc;
        cs = cs ^ cs_flip;
        if (with_csum) begin
`ifdef RISCV_LOADER_CSUM_EN
            send_byte(cs);
`endif
        end
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {26'd0, in_ready, mem_we, mem_sel, core_hold, load_done, load_err}, 32'h0000_0004);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_release", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_next_cycle", {31'd0, in_ready}, 32'd1);

        // junk then single dmem word at address 4
        base = we_addr.size();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h04, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(1'b1, 8'h00);
        settle();
        check("A_strobes", we_addr.size() - base, 32'd1);
        if (we_addr.size() > base) begin
            check("A_sel", {31'd0, we_sel[base]}, 32'd1);
            check("A_addr", {24'd0, we_addr[base]}, 32'd4);
            check("A_wdata", we_data[base], 32'h1234_5678);
            check("A_latency", we_cyc[base], data_end_cyc);
        end
        check("A_status", {29'd0, core_hold, load_done, load_err}, 32'h2);

        // three imem words, valid held high throughout
        base = we_addr.size();
        rl_base = rdy_low;
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                    8'h03, 8'h00, 8'h00, 8'h00};
        send_frame(1'b1, 8'h00);
        settle();
        check("B_strobes", we_addr.size() - base, 32'd3);
        check("B_ready_low", rdy_low - rl_base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (we_addr.size() > base + i) begin
                check("B_addr", {24'd0, we_addr[base+i]}, i);
                check("B_wdata", we_data[base+i], i + 1);
                check("B_sel", {31'd0, we_sel[base+i]}, 32'd0);
            end
        end
        check("B_status", {29'd0, core_hold, load_done, load_err}, 32'h2);

        // bad target byte
        base = we_addr.size();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22};
        send_frame(1'b0, 8'h00);
        settle();
        check("C_status", {29'd0, core_hold, load_done, load_err}, 32'h5);

        // start 0xFE with N=3 overruns the 256-word memory
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'hFE, 8'h00,
                    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(1'b0, 8'h00);
        settle();
        check("D_status", {29'd0, core_hold, load_done, load_err}, 32'h5);
        check("D_strobes", we_addr.size() - base, 32'd0);

        // N=0 frame recovers from the error with no writes
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        send_frame(1'b1, 8'h00);
        settle();
        check("E_status", {29'd0, core_hold, load_done, load_err}, 32'h2);
        check("E_strobes", we_addr.size() - base, 32'd0);

        // exact fit to top of memory, SYNC bytes inside payload
        base = we_addr.size();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'hFD, 8'h00,
                    8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'hFF, 8'hEE, 8'hDD, 8'hCC};
        send_frame(1'b1, 8'h00);
        settle();
        check("F_strobes", we_addr.size() - base, 32'd3);
        if (we_addr.size() >= base + 3) begin
            check("F_addr0", {24'd0, we_addr[base]}, 32'hFD);
            check("F_wdata0", we_data[base], 32'hA5A5_A5A5);
            check("F_addr2", {24'd0, we_addr[base+2]}, 32'hFF);
            check("F_wdata1", we_data[base+1], 32'h0403_0201);
            check("F_wdata2", we_data[base+2], 32'hCCDD_EEFF);
        end
        check("F_status", {29'd0, core_hold, load_done, load_err}, 32'h2);

`ifdef RISCV_LOADER_CSUM_EN
        // corrupt checksum: word stays written, frame flagged as failed
        base = we_addr.size();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b1, 8'h01);
        settle();
        check("G_strobes", we_addr.size() - base, 32'd1);
        check("G_status", {29'd0, core_hold, load_done, load_err}, 32'h5);
`endif

        // reset after two data bytes
        base = we_addr.size();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h20, 8'h00, 8'h78, 8'h56};
        send_frame(1'b0, 8'h00);
        reset = 1'b0;
        #1;
        check("H_rst_ctl", {26'd0, in_ready, mem_we, mem_sel, core_hold, load_done, load_err}, 32'h0000_0004);
        check("H_rst_addr", {24'd0, mem_addr}, 32'd0);
        check("H_rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h21, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        send_frame(1'b1, 8'h00);
        settle();
        check("H_strobes", we_addr.size() - base, 32'd1);
        if (we_addr.size() > base) begin
            check("H_addr", {24'd0, we_addr[base]}, 32'h21);
            check("H_wdata", we_data[base], 32'hAABB_CCDD);
        end
        check("H_status", {29'd0, core_hold, load_done, load_err}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
